reaction_round_ctrl: RTL and testbench
======================================

# reaction_round_ctrl

Round sequencer for the reaction-timer datapath. It runs each round: it waits for the start button, then holds off for a pseudo-random delay and drives the "GO" LEDs. It then measures the player's reaction in milliseconds, flags false starts, and keeps a best-time register. Its outputs feed the 7-segment display driver on ck_io0..ck_io11 and the board LEDs; the button inputs are already synchronised and debounced upstream.

## Interface
Parameters:
- TICK_DIV, 100000 — clk cycles per 1 ms tick (100 MHz clock); benches use 10.
- MIN_DELAY_MS, 1000 — minimum hold-off before GO.
- RAND_BITS, 10 — LFSR bits added to the hold-off (extra 0..2^RAND_BITS-1 ms); range 1..16.
- MAX_MS, 9999 — reaction timeout and saturation value (four display digits).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- ck_rst  in  1  asynchronous, active-low reset.
- btn_start  in  1  start button level, synchronous, debounced.
- btn_react  in  1  reaction button level, synchronous, debounced.
- btn_clr  in  1  clears best time, level.
- rt_ms  out  14  live count in GO; captured result in DONE; 0 in IDLE/ARM/FOUL.
- rt_valid  out  1  high while in DONE.
- best_ms  out  14  best (lowest) valid result.
- new_best  out  1  one-cycle pulse when best_ms is updated.
- false_start  out  1  high while in FOUL.
- leds  out  4  state indication.

## Operation
- Edge detect: start_e and react_e are rising edges, taken from a registered copy of each button (1-cycle detection latency). Buttons held through reset produce no edge.
- LFSR:
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1.
  - It advances every cycle and never holds zero.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick is asserted when it equals TICK_DIV-1.
  - It clears to 0 on every state transition.
- States:
  - IDLE (leds 0001): start_e -> ARM. On that transition, load delay = MIN_DELAY_MS + lfsr[RAND_BITS-1:0] and clear the ms counter.
  - ARM (leds 0010):
    - Counts ms on each tick.
    - react_e -> FOUL.
    - When the counter reaches delay -> GO, and the ms counter clears.
    - start_e is ignored.
  - GO (leds 1111):
    - Counts ms on each tick; rt_ms shows the count.
    - react_e -> DONE. The captured value is the count before any same-cycle tick.
    - If the count reaches MAX_MS -> DONE with a captured value of MAX_MS.
    - start_e is ignored.
  - DONE (leds 0100):
    - rt_valid=1 and rt_ms holds the result.
    - On entry, if result < best_ms, then best_ms <= result and new_best pulses for 1 cycle, coincident with the first DONE cycle.
    - start_e -> ARM (new round, fresh delay load).
  - FOUL (leds 1000): false_start=1; start_e -> ARM.
- Simultaneous events:
  - In IDLE, DONE and FOUL, start_e and react_e together: start wins.
  - In ARM, react_e wins over delay expiry.
  - In GO, react_e wins over timeout.
- btn_clr sets best_ms to MAX_MS in any state.
  - If btn_clr and a best update occur in the same cycle, the update wins.
- Arithmetic:
  - The ms counter is 14 bits and saturates at MAX_MS; it never wraps.
  - delay is 17 bits, and its sum is unsigned.

## Timing
- Reset values:
  - State IDLE; leds=0001; rt_ms=0; rt_valid=0; best_ms=MAX_MS; new_best=0; false_start=0.
  - LFSR=16'hACE1; prescaler=0; edge registers=0.
- All outputs are registered.
  - A state change is visible on leds 1 cycle after the edge-detected input, which is 2 cycles after the button rises.
- ARM to GO: exactly delay*TICK_DIV cycles after entering ARM.
- The measured reaction is floor((cycles from GO entry to react_e) / TICK_DIV).
- Reset asserted mid-round returns to IDLE immediately (asynchronously) and clears best_ms.

## Test plan
1. Reset with btn_start held high -> state stays IDLE, leds=0001, best_ms=9999.
2. Normal round (TICK_DIV=10, MIN_DELAY_MS=4, RAND_BITS=2):
   - Stimulus: start edge, then react 53 cycles after GO entry.
   - Required: leds go 0010 for (4+lfsr[1:0])*10 cycles, then 1111; then DONE with rt_ms=5, rt_valid=1, best_ms=5 and a one-cycle new_best.
3. React 2 cycles into ARM -> FOUL, leds=1000, false_start=1, best_ms unchanged; a following start edge -> ARM.
4. Never react in GO (MAX_MS=20, TICK_DIV=10):
   - Required: DONE after 200 cycles, rt_ms=20, and no new_best while best_ms=5.
5. Second round with result 7 while best_ms=5 -> best_ms stays 5, no new_best. Then assert btn_clr -> best_ms=MAX_MS.
6. Assert ck_rst low mid-GO -> all outputs at reset values within the same cycle; after release, a start edge begins a fresh round.

Source files
------------

// File: rtl/reaction_round_ctrl.sv
// Reaction-timer round sequencer: randomized hold-off, GO indication, millisecond
// reaction measurement, false-start detection and best-time tracking.
module reaction_round_ctrl #(
  parameter int TICK_DIV     = 100000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 10,
  parameter int MAX_MS       = 9999
) (
  input  logic        clk,
  input  logic        ck_rst,
  input  logic        btn_start,
  input  logic        btn_react,
  input  logic        btn_clr,
  output logic [13:0] rt_ms,
  output logic        rt_valid,
  output logic [13:0] best_ms,
  output logic        new_best,
  output logic        false_start,
  output logic [3:0]  leds
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [13:0]   MAX_V    = 14'(MAX_MS);
  localparam logic [16:0]   MIN_V    = 17'(MIN_DELAY_MS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_GO   = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_FOUL = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [13:0]   ms_q, ms_d;
  logic [16:0]   delay_q, delay_d;
  logic [1:0]    sync_q, sync_d, hist_q, hist_d, ready_q, ready_d;
  logic [13:0]   rt_ms_q, rt_ms_d, best_q, best_d;
  logic          rt_valid_q, rt_valid_d, new_best_q, new_best_d;
  logic          false_start_q, false_start_d;
  logic [3:0]    leds_q, leds_d;

  logic [1:0]  btn_w, edge_w;
  logic        start_e, react_e, tick;
  logic [13:0] ms_inc, cap_w;
  logic [16:0] rand_w;

  assign btn_w = {btn_react, btn_start};

  // Edges are masked for two cycles after reset so a button held through reset is not seen as a press.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_edge
      assign edge_w[gi] = sync_q[gi] & ~hist_q[gi] & ready_q[1];
    end
  endgenerate

  assign start_e = edge_w[0];
  assign react_e = edge_w[1];
  assign tick    = (pre_q == PRE_LAST);
  assign ms_inc  = (ms_q == MAX_V) ? ms_q : ms_q + 14'd1;
  assign rand_w  = 17'(lfsr_q[RAND_BITS-1:0]);

  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    delay_d = delay_q;
    cap_w   = 14'd0;
    sync_d  = btn_w;
    hist_d  = sync_q;
    ready_d = {ready_q[0], 1'b1};
    lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    case (state_q)
      S_IDLE, S_DONE, S_FOUL: begin
        if (start_e) begin
          state_d = S_ARM;
          delay_d = MIN_V + rand_w;
          ms_d    = 14'd0;
        end
      end
      S_ARM: begin
        if (react_e) begin
          state_d = S_FOUL;
        end else if (tick && ({3'b000, ms_inc} >= delay_q)) begin
          state_d = S_GO;
          ms_d    = 14'd0;
        end else if (tick) begin
          ms_d = ms_inc;
        end
      end
      S_GO: begin
        // The captured value is the count before any tick landing in the same cycle.
        if (react_e) begin
          state_d = S_DONE;
          cap_w   = ms_q;
        end else if (tick && (ms_inc >= MAX_V)) begin
          state_d = S_DONE;
          cap_w   = MAX_V;
        end else if (tick) begin
          ms_d = ms_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) pre_d = '0;
    else if (tick)          pre_d = '0;
    else                    pre_d = pre_q + 1'b1;

    case (state_d)
      S_GO:    rt_ms_d = ms_d;
      S_DONE:  rt_ms_d = (state_q == S_DONE) ? rt_ms_q : cap_w;
      default: rt_ms_d = 14'd0;
    endcase

    new_best_d = (state_d == S_DONE) && (state_q != S_DONE) && (cap_w < best_q);
    if (new_best_d)   best_d = cap_w;
    else if (btn_clr) best_d = MAX_V;
    else              best_d = best_q;

    rt_valid_d    = (state_d == S_DONE);
    false_start_d = (state_d == S_FOUL);
    case (state_d)
      S_ARM:   leds_d = 4'b0010;
      S_GO:    leds_d = 4'b1111;
      S_DONE:  leds_d = 4'b0100;
      S_FOUL:  leds_d = 4'b1000;
      default: leds_d = 4'b0001;
    endcase
  end

  always_ff @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) begin
      state_q       <= S_IDLE;
      lfsr_q        <= 16'hACE1;
      pre_q         <= '0;
      ms_q          <= 14'd0;
      delay_q       <= 17'd0;
      sync_q        <= 2'b00;
      hist_q        <= 2'b00;
      ready_q       <= 2'b00;
      rt_ms_q       <= 14'd0;
      rt_valid_q    <= 1'b0;
      best_q        <= MAX_V;
      new_best_q    <= 1'b0;
      false_start_q <= 1'b0;
      leds_q        <= 4'b0001;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      pre_q         <= pre_d;
      ms_q          <= ms_d;
      delay_q       <= delay_d;
      sync_q        <= sync_d;
      hist_q        <= hist_d;
      ready_q       <= ready_d;
      rt_ms_q       <= rt_ms_d;
      rt_valid_q    <= rt_valid_d;
      best_q        <= best_d;
      new_best_q    <= new_best_d;
      false_start_q <= false_start_d;
      leds_q        <= leds_d;
    end
  end

  assign rt_ms       = rt_ms_q;
  assign rt_valid    = rt_valid_q;
  assign best_ms     = best_q;
  assign new_best    = new_best_q;
  assign false_start = false_start_q;
  assign leds        = leds_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Randomized round-level bench for reaction_round_ctrl; expected timings and results
// come from the round rules (delay, floor(cycles/TICK_DIV), timeout, best tracking).
module tb_reaction_round_ctrl;

  localparam int TDIV    = 10;
  localparam int MIN_DLY = 4;
  localparam int RBITS   = 2;
  localparam int MAXV    = 20;

  logic        clk = 1'b0;
  logic        ck_rst = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_react = 1'b0;
  logic        btn_clr = 1'b0;
  logic [13:0] rt_ms, best_ms;
  logic        rt_valid, new_best, false_start;
  logic [3:0]  leds;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int best_m = MAXV;

  reaction_round_ctrl #(
    .TICK_DIV(TDIV), .MIN_DELAY_MS(MIN_DLY), .RAND_BITS(RBITS), .MAX_MS(MAXV)
  ) dut (
    .clk(clk), .ck_rst(ck_rst), .btn_start(btn_start), .btn_react(btn_react),
    .btn_clr(btn_clr), .rt_ms(rt_ms), .rt_valid(rt_valid), .best_ms(best_ms),
    .new_best(new_best), .false_start(false_start), .leds(leds)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; the pseudo-random source advances once per edge.
  always @(posedge clk or negedge ck_rst) begin
    if (!ck_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < n; i++) l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    return l;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_leds"}, leds, 4'b0001);
    check_val({tag, "_rt"}, rt_ms, 0);
    check_val({tag, "_valid"}, rt_valid, 0);
    check_val({tag, "_best"}, best_ms, MAXV);
    check_val({tag, "_newbest"}, new_best, 0);
    check_val({tag, "_foul"}, false_start, 0);
  endtask

  // mode 0: react c cycles after GO entry; 1: never react; 2: react at ARM sample c;
  // 3: reset after c cycles of GO.
  task automatic do_round(input int mode, input int c);
    int d, n, expv;
    logic [15:0] l;
    btn_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    btn_start = 1'b0;
    check_val("arm_leds", leds, 4'b0010);
    check_val("arm_rt", rt_ms, 0);
    check_val("arm_valid", rt_valid, 0);
    l = lfsr_at(cyc - 1);
    d = MIN_DLY + int'(l[RBITS-1:0]);
    if (mode == 2) begin
      repeat (c) @(negedge clk);
      btn_react = 1'b1;
      @(negedge clk);
      @(negedge clk);
      btn_react = 1'b0;
      check_val("foul_leds", leds, 4'b1000);
      check_val("foul_flag", false_start, 1);
      check_val("foul_rt", rt_ms, 0);
      check_val("foul_best", best_ms, best_m);
      check_val("foul_newbest", new_best, 0);
      $display("round mode=foul arm_sample=%0d delay=%0d best=%0d", c, d, best_ms);
      return;
    end
    n = 0;
    while (leds == 4'b0010 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check_val("arm_len", n, d * TDIV);
    check_val("go_leds", leds, 4'b1111);
    if (mode == 3) begin
      for (int j = 0; j < c; j++) begin
        check_val("go_rt", rt_ms, j / TDIV);
        @(negedge clk);
      end
      ck_rst = 1'b0;
      #1;
      best_m = MAXV;
      check_reset_outputs("midgo_rst");
      $display("round mode=reset go_cycles=%0d delay=%0d", c, d);
      @(negedge clk);
      ck_rst = 1'b1;
      repeat (2) @(negedge clk);
      return;
    end
    if (mode == 1) begin
      for (int j = 0; j < MAXV * TDIV; j++) begin
        check_val("go_rt", rt_ms, j / TDIV);
        @(negedge clk);
      end
      expv = MAXV;
    end else begin
      for (int j = 0; j < c - 1; j++) begin
        check_val("go_rt", rt_ms, j / TDIV);
        @(negedge clk);
      end
      btn_react = 1'b1;
      @(negedge clk);
      @(negedge clk);
      btn_react = 1'b0;
      expv = c / TDIV;
    end
    check_val("done_leds", leds, 4'b0100);
    check_val("done_rt", rt_ms, expv);
    check_val("done_valid", rt_valid, 1);
    check_val("done_newbest", new_best, (expv < best_m) ? 1 : 0);
    if (expv < best_m) best_m = expv;
    check_val("done_best", best_ms, best_m);
    @(negedge clk);
    check_val("done_newbest_pulse", new_best, 0);
    check_val("done_hold_rt", rt_ms, expv);
    $display("round mode=%s react_at=%0d delay=%0d result=%0d best=%0d",
             (mode == 1) ? "timeout" : "react", c, d, rt_ms, best_ms);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mode, c;
    btn_start = 1'b1;
    ck_rst    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    ck_rst = 1'b1;
    repeat (5) @(negedge clk);
    check_val("held_start_leds", leds, 4'b0001);
    check_val("held_start_valid", rt_valid, 0);
    btn_start = 1'b0;
    repeat (2) @(negedge clk);

    do_round(0, 53);
    do_round(2, 2);
    do_round(1, 0);
    do_round(0, 75);

    btn_clr = 1'b1;
    @(negedge clk);
    btn_clr = 1'b0;
    best_m = MAXV;
    check_val("clr_best", best_ms, MAXV);
    check_val("clr_newbest", new_best, 0);
    $display("clear best=%0d", best_ms);

    for (int k = 0; k < 6; k++) begin
      mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      c = (mode == 2) ? $urandom_range(0, 20) : $urandom_range(1, MAXV * TDIV - 1);
      do_round(mode, c);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    do_round(0, MAXV * TDIV - 1);
    do_round(3, $urandom_range(1, 150));
    do_round(0, $urandom_range(1, MAXV * TDIV - 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
